// File: rtl/branch_seq_pkg.sv
// Shared branch-mode codes and status-flag indices for the next-PC sequencer.
package branch_seq_pkg;

  localparam logic [2:0] BS_INC       = 3'b000;
  localparam logic [2:0] BS_BR_COND   = 3'b001;
  localparam logic [2:0] BS_JMP_REL   = 3'b010;
  localparam logic [2:0] BS_JMP_ABS   = 3'b011;
  localparam logic [2:0] BS_CALL      = 3'b100;
  localparam logic [2:0] BS_RET       = 3'b101;
  localparam logic [2:0] BS_CALL_COND = 3'b110;
  localparam logic [2:0] BS_RSVD      = 3'b111;

  localparam int unsigned FLG_Z = 0;
  localparam int unsigned FLG_N = 1;
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_V = 3;

endpackage

// File: rtl/branch_seq_unit_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module return_addr_stack #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] sp_q, sp_d, top_idx, wr_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en;

  assign top_idx = sp_q - PW'(1);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign dout    = mem_q[top_idx];

  // sp points at the next free slot; push+pop on a non-empty stack rewrites the top
  always_comb begin
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = sp_q;
    if (push && pop && !empty) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push) begin
      wr_en = 1'b1;
      sp_d  = sp_q + PW'(1);
      if (!full) cnt_d = cnt_q + CW'(1);
    end else if (pop && !empty) begin
      sp_d  = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/branch_seq_unit.sv
// Next-PC sequencer: PC register, flag condition, branch-mode decode and call/return stack.
module branch_seq_unit
  import branch_seq_pkg::*;
#(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned NFLAGS    = 4,
  parameter int unsigned RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [2:0]                   bs,
  input  logic                         ps,
  input  logic [$clog2(NFLAGS)-1:0]    flag_sel,
  input  logic [NFLAGS-1:0]            flags,
  input  logic [PC_W-1:0]              offset,
  input  logic [PC_W-1:0]              target,
  output logic [PC_W-1:0]              pc,
  output logic                         taken,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int unsigned FSW = $clog2(NFLAGS);

  logic [PC_W-1:0] pc_q, pc_d, pc_inc, ras_dout;
  logic            taken_q, taken_d;
  logic            of_q, of_d, uf_q, uf_d;
  logic            push, pop, ras_empty, ras_full;
  logic            flag_bit, cond;

  // Out-of-range selects read as 0 so the condition degenerates to ps
  assign flag_bit = (32'(flag_sel) < NFLAGS) ? flags[flag_sel] : 1'b0;
  assign cond     = flag_bit ^ ps;
  assign pc_inc   = pc_q + PC_W'(1);

  return_addr_stack #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (ras_dout),
    .count (ras_count),
    .empty (ras_empty),
    .full  (ras_full)
  );

  always_comb begin
    pc_d    = pc_q;
    taken_d = 1'b0;
    of_d    = of_q;
    uf_d    = uf_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (en) begin
      pc_d = pc_inc;
      unique case (bs)
        BS_BR_COND: if (cond) begin
          pc_d    = pc_q + offset;
          taken_d = 1'b1;
        end
        BS_JMP_REL: begin
          pc_d    = pc_q + offset;
          taken_d = 1'b1;
        end
        BS_JMP_ABS: begin
          pc_d    = target;
          taken_d = 1'b1;
        end
        BS_CALL, BS_CALL_COND: if (bs == BS_CALL || cond) begin
          push    = 1'b1;
          pc_d    = target;
          taken_d = 1'b1;
          if (ras_full) of_d = 1'b1;
        end
        BS_RET: begin
          if (ras_empty) begin
            uf_d = 1'b1;
          end else begin
            pop     = 1'b1;
            pc_d    = ras_dout;
            taken_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      of_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      of_q    <= of_d;
      uf_q    <= uf_d;
    end
  end

  assign pc            = pc_q;
  assign taken         = taken_q;
  assign ras_overflow  = of_q;
  assign ras_underflow = uf_q;

endmodule
